// File: rtl/arbiter4_rr_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared sizes, FSM state type and small helper functions for
//               the 4-way round-robin arbiter.
//               N_REQ - number of requesters
//               ID_W  - width of a binary requester index
// Optional    : ARB_TIMEOUT_EN (consumed by arbiter4_rr, not by this package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Rotate right so that bit 'sh' of v lands at bit 0; this turns the
  // "start at ptr" search into a plain lowest-index-wins search.
  function automatic logic [N_REQ-1:0] rotate_right(
    input logic [N_REQ-1:0] v,
    input logic [ID_W-1:0]  sh
  );
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[N_REQ-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter4_rr_if.sv
// ============================================================================
// Module      : arbiter4_rr_if
// Description : Request/grant bundle of the 4-way round-robin arbiter.
//               req       - request lines, one per requester
//               gnt       - one-hot grant
//               gnt_id    - binary index of the holder (0 when no grant)
//               gnt_valid - a grant is active
//               timeout   - one-cycle pulse when the hold limit ends a grant
//               master : requester side (drives req)
//               slave  : arbiter side  (drives grant signals)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbiter4_rr_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);

endinterface

`default_nettype wire

// File: rtl/arbiter4_rr_prio_enc4.sv
// ============================================================================
// Module      : prio_enc4
// Description : Combinational 4:2 priority encoder, lowest index wins.
//               in_vec - 4-bit input vector
//               idx    - index of the lowest set bit (0 when none set)
//               valid  - at least one input bit set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_vec,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  always_comb begin
    idx = 2'd0;
    if (in_vec[0])      idx = 2'd0;
    else if (in_vec[1]) idx = 2'd1;
    else if (in_vec[2]) idx = 2'd2;
    else if (in_vec[3]) idx = 2'd3;
  end

  assign valid = |in_vec;

endmodule

`default_nettype wire

// File: rtl/arbiter4_rr.sv
// ============================================================================
// Module      : arbiter4_rr
// Description : 4-way round-robin arbiter, non-preemptive, registered grant.
//               A grant is held while the holder keeps requesting; release
//               always inserts one cycle with no grant before the next
//               arbitration.
//               clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - arbiter4_rr_if.slave (req in; gnt, gnt_id,
//                       gnt_valid, timeout out)
// Parameter   : HOLD_MAX - max consecutive grant cycles (1..255), only
//               effective with the hold-limit option
// Optional    : `define ARB_TIMEOUT_EN builds the hold counter and timeout;
//               without it timeout is tied low and grants never expire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter4_rr
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  arbiter4_rr_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("arbiter4_rr: HOLD_MAX must be within 1..255");
  end

  state_t           r_state,     w_state_nxt;
  logic [ID_W-1:0]  r_ptr,       w_ptr_nxt;
  logic [N_REQ-1:0] r_gnt,       w_gnt_nxt;
  logic [ID_W-1:0]  r_gnt_id,    w_gnt_id_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;

  logic [N_REQ-1:0] w_rot_req;
  logic [ID_W-1:0]  w_enc_idx;
  logic             w_enc_valid;
  logic [ID_W-1:0]  w_winner;
  logic             w_release;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
  logic       r_timeout,  w_timeout_nxt;
`endif

  // Search starts at ptr; the encoder's index is relative to ptr, so adding
  // ptr back (2-bit wrap = mod 4) gives the absolute winner.
  assign w_rot_req = rotate_right(bus.req, r_ptr);

  prio_enc4 u_prio_enc4 (
    .in_vec (w_rot_req),
    .idx    (w_enc_idx),
    .valid  (w_enc_valid)
  );

  assign w_winner = w_enc_idx + r_ptr;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_release       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_cnt_nxt  = r_hold_cnt;
    w_timeout_nxt   = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_nxt     = BUSY;
          w_gnt_nxt       = onehot(w_winner);
          w_gnt_id_nxt    = w_winner;
          w_gnt_valid_nxt = 1'b1;
          w_ptr_nxt       = w_winner + 2'd1;
`ifdef ARB_TIMEOUT_EN
          w_hold_cnt_nxt  = 8'd1;
`endif
        end
      end

      BUSY: begin
        w_release = !bus.req[r_gnt_id];
`ifdef ARB_TIMEOUT_EN
        // Counter holds the number of cycles the grant has been visible;
        // at HOLD_MAX the grant is withdrawn even though req is still high.
        if (!w_release) begin
          if (r_hold_cnt == 8'(HOLD_MAX)) begin
            w_release     = 1'b1;
            w_timeout_nxt = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
          end
        end
`endif
        if (w_release) begin
          w_state_nxt     = IDLE;
          w_gnt_nxt       = '0;
          w_gnt_id_nxt    = '0;
          w_gnt_valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
          w_hold_cnt_nxt  = 8'd0;
`endif
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_gnt_nxt       = '0;
        w_gnt_id_nxt    = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;

endmodule

`default_nettype wire

// File: doc/arbiter4_rr.md
ARBITER4_RR -- requirements
Module: arbiter4_rr

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles per holder; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared resource.
REQ-005 gnt  output  4  one-hot grant; at most one bit high.
REQ-006 gnt_id  output  2  binary index of the current holder; 2'b00 when gnt_valid is low.
REQ-007 gnt_valid  output  1  high when exactly one gnt bit is high.
REQ-008 timeout  output  1  one-cycle pulse when a grant is withdrawn by the hold limit.

Function
REQ-009 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-010 In IDLE with req != 0, the FSM SHALL select a winner by round-robin and enter BUSY on the next rising edge, with gnt, gnt_id and gnt_valid registered (1-cycle latency from req to gnt).
REQ-011 Round-robin order SHALL start at index ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requester found in that order wins.
REQ-012 On each grant to index k, ptr SHALL update to (k+1) mod 4.
REQ-013 In IDLE with req == 0, the FSM SHALL remain in IDLE with all outputs low and ptr unchanged.
REQ-014 In BUSY, the grant SHALL hold while req[holder] stays high; other requests SHALL be ignored (no preemption).
REQ-015 When req[holder] is low at a rising edge in BUSY, the FSM SHALL return to IDLE and drive gnt to 0 for at least one cycle (release gap); re-arbitration then follows REQ-010.
REQ-016 gnt_id SHALL always equal the binary encoding of gnt; gnt_valid SHALL equal |gnt.
REQ-017 If req changes during the IDLE cycle, the winner SHALL be chosen from req as sampled at that edge.
REQ-018 A requester granted in consecutive arbitrations SHALL win only when no other requester is pending (fairness bound: any pending requester is granted within 3 other grants).

Reset
REQ-019 Asserting rst_n low SHALL immediately force state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, hold counter=0, regardless of clock.
REQ-020 Reset asserted during BUSY SHALL drop the grant without a timeout pulse; after deassertion, arbitration restarts from ptr=0.

Configuration
REQ-021 Macro ARB_TIMEOUT_EN SHALL compile in a hold counter: counts BUSY cycles; when it reaches HOLD_MAX with req[holder] still high, the FSM SHALL go to IDLE, clear gnt, and pulse timeout for one cycle.
REQ-022 After a timeout, ptr SHALL already point past the holder, so another pending requester wins next; if the holder is the sole requester, it SHALL be re-granted after the release gap.
REQ-023 Without ARB_TIMEOUT_EN, no counter SHALL be built, the timeout port SHALL remain present and tied to 0, and grants SHALL be held indefinitely.

Structure
REQ-024 Package arb_pkg SHALL hold N_REQ=4, ID_W=2, and the state enumeration (IDLE, BUSY).
REQ-025 The rotated-priority search SHALL use one sub-module, prio_enc4: combinational 4:2 priority encoder (input 4-bit, outputs 2-bit index and valid, lowest index wins), fed by req rotated by ptr; the result index SHALL be un-rotated by adding ptr mod 4.

Verification
REQ-026 Reset, then req=4'b0101 -> next edge gnt=4'b0001, gnt_id=0; drop req[0] -> one idle cycle, then gnt=4'b0100, gnt_id=2.
REQ-027 req=4'b1111 held, each holder releases after 2 cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-028 Holder 1 keeps req high while req[3] rises -> gnt stays 4'b0010 (no preemption) until req[1] falls.
REQ-029 ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held forever -> gnt=4'b0001 for 4 cycles, timeout pulse, idle cycle, gnt=4'b0010 for 4 cycles, timeout pulse.
REQ-030 rst_n pulsed low mid-BUSY, asynchronous to clk -> outputs 0 immediately, timeout stays 0; with req=4'b1000 after release, gnt=4'b1000 one edge later.
REQ-031 All runs: assert gnt one-hot-or-zero, gnt_id consistent with gnt, and no req=0 cycle produces a grant.
